// File: rtl/score_display.sv
// Decimal BCD score counter with an on-screen 3x5 glyph renderer.
// The pixel path is a two-stage pipeline: coordinate decode, then glyph lookup.
module score_display #(
   parameter int         DIGITS     = 2,
   parameter int         SCALE_LOG2 = 2,
   parameter logic [9:0] X0         = 10'd288,
   parameter logic [9:0] Y0         = 10'd16,
   parameter bit         LEAD_BLANK = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  score_inc,
   input  logic                  score_clr,
   input  logic                  video_on,
   input  logic [9:0]            pixel_x,
   input  logic [9:0]            pixel_y,
   output logic                  pixel,
   output logic [4*DIGITS-1:0]   score_bcd,
   output logic                  wrap
);

   localparam logic [10:0] BOX_W = 11'(DIGITS * 4 * (1 << SCALE_LOG2));
   localparam logic [10:0] BOX_H = 11'(5 * (1 << SCALE_LOG2));
   localparam logic [10:0] X_END = {1'b0, X0} + BOX_W;
   localparam logic [10:0] Y_END = {1'b0, Y0} + BOX_H;

   logic [4*DIGITS-1:0] score_q, score_d, score_plus1;
   logic                wrap_q, wrap_d;
   logic [DIGITS:0]     nines;

   // nines[i] is set when every digit below i is 9, i.e. digit i receives a carry
   assign nines[0] = 1'b1;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_cnt
         logic [3:0] nib;
         assign nib                    = score_q[4*gi +: 4];
         assign nines[gi+1]            = nines[gi] & (nib == 4'd9);
         assign score_plus1[4*gi +: 4] = !nines[gi]    ? nib  :
                                         (nib == 4'd9) ? 4'd0 : nib + 4'd1;
      end
   endgenerate

   always_comb begin
      score_d = score_q;
      wrap_d  = 1'b0;
      if (score_clr) begin
         score_d = '0;
      end else if (score_inc) begin
         if (nines[DIGITS]) begin
            score_d = '0;
            wrap_d  = 1'b1;
         end else begin
            score_d = score_plus1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         score_q <= score_d;
         wrap_q  <= wrap_d;
      end
   end

   // Stage 1: box test and cell decode
   logic [9:0] relx, rely;
   logic       in_box;
   logic       in_q, von_q;
   logic [1:0] slot_q, col_q;
   logic [2:0] row_q;

   assign relx   = pixel_x - X0;
   assign rely   = pixel_y - Y0;
   assign in_box = (pixel_x >= X0) && ({1'b0, pixel_x} < X_END) &&
                   (pixel_y >= Y0) && ({1'b0, pixel_y} < Y_END);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_q   <= 1'b0;
         von_q  <= 1'b0;
         slot_q <= 2'd0;
         col_q  <= 2'd0;
         row_q  <= 3'd0;
      end else begin
         in_q   <= in_box;
         von_q  <= video_on;
         slot_q <= 2'(relx >> (SCALE_LOG2 + 2));
         col_q  <= 2'(relx >> SCALE_LOG2);
         row_q  <= 3'(rely >> SCALE_LOG2);
      end
   end

   // Stage 2: digits padded to four so a 2-bit slot index is always in range
   logic [3:0] dig [4];
   logic [4:0] lead_zero;
   logic [3:0] blank;

   assign lead_zero[4] = 1'b1;

   generate
      for (gi = 0; gi < 4; gi++) begin : g_dig
         if (gi < DIGITS) begin : g_real
            assign dig[gi] = score_q[4*gi +: 4];
         end else begin : g_pad
            assign dig[gi] = 4'd0;
         end
         assign lead_zero[gi] = lead_zero[gi+1] & (dig[gi] == 4'd0);
         if (gi == 0) begin : g_lsd
            assign blank[gi] = 1'b0;
         end else begin : g_msd
            assign blank[gi] = LEAD_BLANK & lead_zero[gi];
         end
      end
   endgenerate

   function automatic logic [14:0] glyph(input logic [3:0] d);
      case (d)
         4'd0:    glyph = 15'b111_101_101_101_111;
         4'd1:    glyph = 15'b010_110_010_010_010;
         4'd2:    glyph = 15'b111_101_011_100_111;
         4'd3:    glyph = 15'b111_001_111_001_111;
         4'd4:    glyph = 15'b101_101_111_001_001;
         4'd5:    glyph = 15'b111_100_111_001_111;
         4'd6:    glyph = 15'b111_100_111_101_111;
         4'd7:    glyph = 15'b111_001_010_010_100;
         4'd8:    glyph = 15'b111_101_111_101_111;
         4'd9:    glyph = 15'b111_101_111_001_111;
         default: glyph = 15'd0;
      endcase
   endfunction

   logic [1:0]  digit_idx;
   logic [3:0]  cell_idx;
   logic [14:0] glyph_bits, glyph_shift;
   logic        pixel_q, pixel_d;

   assign digit_idx   = 2'(DIGITS - 1) - slot_q;
   assign cell_idx    = 4'd14 - (4'(row_q) * 4'd3 + {2'b00, col_q});
   assign glyph_bits  = glyph(dig[digit_idx]);
   assign glyph_shift = glyph_bits >> cell_idx;
   assign pixel_d     = in_q & von_q & (col_q != 2'd3) & ~blank[digit_idx] & glyph_shift[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pixel_q <= 1'b0;
      end else begin
         pixel_q <= pixel_d;
      end
   end

   assign pixel     = pixel_q;
   assign score_bcd = score_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_score_display.sv
// Randomised bench for score_display with a decimal/arithmetic reference model
// plus directed counter, glyph, latency and asynchronous-reset checks.
module tb_score_display;

   localparam int X0 = 288;
   localparam int Y0 = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       inc_r = 1'b0, clr_r = 1'b0, vo = 1'b0;
   logic [9:0] px = 10'd0, py = 10'd0;
   logic       pixel;
   logic [7:0] score_bcd;
   logic       wrap;

   int  total = 0;
   int  bad   = 0;
   bit  chk_en = 1'b0;

   score_display dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .score_inc (inc_r),
      .score_clr (clr_r),
      .video_on  (vo),
      .pixel_x   (px),
      .pixel_y   (py),
      .pixel     (pixel),
      .score_bcd (score_bcd),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   // Font rows, top to bottom, MSB = leftmost column
   localparam int FONT [10][5] = '{
      '{7,5,5,5,7}, '{2,6,2,2,2}, '{7,5,3,4,7}, '{7,1,7,1,7}, '{5,5,7,1,1},
      '{7,4,7,1,7}, '{7,4,7,5,7}, '{7,1,2,2,4}, '{7,5,7,5,7}, '{7,5,7,1,7}
   };

   function automatic int model_pixel(input int x, input int y, input bit von, input int sc);
      int rx, slot, col, row, d, p10, dv;
      if (!von) return 0;
      if (x < X0 || x >= X0 + 32 || y < Y0 || y >= Y0 + 20) return 0;
      rx   = x - X0;
      slot = rx / 16;
      col  = (rx / 4) % 4;
      row  = (y - Y0) / 4;
      if (col == 3) return 0;
      d   = 1 - slot;
      p10 = (d == 0) ? 1 : 10;
      dv  = (sc / p10) % 10;
      if (d > 0 && sc < p10) return 0;
      return (FONT[dv][row] >> (2 - col)) & 1;
   endfunction

   function automatic logic [7:0] to_bcd(input int s);
      return {4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: score as an integer, plus a one-deep delay line of inputs
   int  score_m = 0;
   bit  wrap_m = 0, pix_m = 0, s1_v = 0, s1_von = 0;
   int  s1_x = 0, s1_y = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         score_m = 0; wrap_m = 0; pix_m = 0; s1_v = 0;
      end else begin
         pix_m  = s1_v ? bit'(model_pixel(s1_x, s1_y, s1_von, score_m)) : 1'b0;
         s1_x   = int'(px);
         s1_y   = int'(py);
         s1_von = vo;
         s1_v   = 1'b1;
         if (clr_r) begin
            score_m = 0; wrap_m = 0;
         end else if (inc_r) begin
            wrap_m  = (score_m == 99);
            score_m = (score_m + 1) % 100;
         end else begin
            wrap_m = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("score_bcd", score_bcd, to_bcd(score_m));
         check("wrap", wrap, wrap_m);
         check("pixel", pixel, pix_m);
      end
   end

   task automatic rand_coords();
      px = 10'(X0 - 2 + $urandom_range(0, 35));
      py = 10'(Y0 - 2 + $urandom_range(0, 23));
      vo = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) px = 10'($urandom_range(0, 1023));
   endtask

   task automatic cyc(input bit inc, input bit clr);
      @(negedge clk);
      inc_r = inc;
      clr_r = clr;
      rand_coords();
   endtask

   task automatic set_score(input int n);
      cyc(0, 1);
      for (int i = 0; i < n; i++) cyc(1, 0);
      cyc(0, 0);
   endtask

   task automatic park();
      @(negedge clk);
      inc_r = 0; clr_r = 0; px = 10'd0; py = 10'd0; vo = 1'b0;
      @(negedge clk);
   endtask

   // Drives one coordinate for one cycle from a parked state; pixel must stay
   // dark after one edge and show the result after the second.
   task automatic probe(input int x, input int y, input bit von, input bit exp, input string nm);
      @(negedge clk);
      px = 10'(x); py = 10'(y); vo = von;
      @(posedge clk); #1;
      check({nm, "_lat1"}, pixel, 1'b0);
      @(negedge clk);
      px = 10'd0; py = 10'd0; vo = 1'b0;
      @(posedge clk); #1;
      check(nm, pixel, exp);
      $display("probe %s x=%0d y=%0d von=%0d pixel=%0d", nm, x, y, von, pixel);
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check("rst_score", score_bcd, 8'h00);
      check("rst_wrap", wrap, 1'b0);
      check("rst_pixel", pixel, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      chk_en = 1'b1;

      // Twelve increments
      for (int i = 0; i < 12; i++) cyc(1, 0);
      @(posedge clk); #1;
      check("inc12", score_bcd, 8'h12);
      check("inc12_wrap", wrap, 1'b0);
      $display("txn inc12 score=%h wrap=%0d", score_bcd, wrap);

      // Rollover from 99
      cyc(0, 1);
      for (int i = 0; i < 99; i++) cyc(1, 0);
      @(posedge clk); #1;
      check("at99", score_bcd, 8'h99);
      cyc(1, 0);
      @(posedge clk); #1;
      check("wrap_score", score_bcd, 8'h00);
      check("wrap_pulse", wrap, 1'b1);
      cyc(0, 0);
      @(posedge clk); #1;
      check("wrap_end", wrap, 1'b0);
      $display("txn rollover score=%h wrap=%0d", score_bcd, wrap);

      // Clear wins over increment
      cyc(0, 1);
      for (int i = 0; i < 45; i++) cyc(1, 0);
      @(posedge clk); #1;
      check("at45", score_bcd, 8'h45);
      cyc(1, 1);
      @(posedge clk); #1;
      check("clr_win", score_bcd, 8'h00);
      check("clr_wrap", wrap, 1'b0);
      cyc(0, 0);
      $display("txn clr_vs_inc score=%h wrap=%0d", score_bcd, wrap);

      // Full scan at score 07
      set_score(7);
      check("model_pin_a", model_pixel(X0 + 24, Y0 + 4, 1, 7), 1);
      check("model_pin_b", model_pixel(X0, Y0, 1, 7), 0);
      for (int y = Y0 - 1; y <= Y0 + 20; y++) begin
         for (int x = X0 - 1; x <= X0 + 32; x++) begin
            @(negedge clk);
            px = 10'(x); py = 10'(y); vo = 1'b1;
         end
      end
      park();
      $display("txn scan score=07 done");
      probe(X0 + 16, Y0,      1'b0, 1'b0, "von_off");
      probe(X0 + 16, Y0,      1'b1, 1'b1, "seven_r0c0");
      probe(X0 + 19, Y0 + 3,  1'b1, 1'b1, "seven_scale");
      probe(X0,      Y0,      1'b1, 1'b0, "lead_blank");
      probe(X0 + 12, Y0,      1'b1, 1'b0, "gap_slot0");
      probe(X0 + 28, Y0,      1'b1, 1'b0, "gap_slot1");
      probe(X0 + 24, Y0 + 4,  1'b1, 1'b1, "seven_r1c2");
      probe(X0 + 16, Y0 + 4,  1'b1, 1'b0, "seven_r1c0");
      probe(X0 + 16, Y0 + 16, 1'b1, 1'b1, "seven_r4c0");
      probe(X0 + 20, Y0 + 16, 1'b1, 1'b0, "seven_r4c1");
      probe(X0 + 16, Y0 + 20, 1'b1, 1'b0, "below_box");
      probe(X0 + 32, Y0,      1'b1, 1'b0, "right_of_box");

      // Randomised traffic
      for (int i = 0; i < 4000; i++) cyc($urandom_range(0, 1) == 1, $urandom_range(0, 63) == 0);
      $display("txn random 4000 cycles score=%h", score_bcd);

      // Asynchronous reset between edges at score 33
      set_score(33);
      @(negedge clk);
      px = 10'(X0 + 16); py = 10'(Y0); vo = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("pre_rst_pixel", pixel, 1'b1);
      check("pre_rst_score", score_bcd, 8'h33);
      #1;
      rst_n = 1'b0;
      #1;
      check("async_score", score_bcd, 8'h00);
      check("async_pixel", pixel, 1'b0);
      check("async_wrap", wrap, 1'b0);
      $display("txn async_reset score=%h pixel=%0d", score_bcd, pixel);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_lat1", pixel, 1'b0);
      @(posedge clk); #1;
      check("post_rst_lat2", pixel, 1'b1);
      $display("txn post_reset pixel=%0d", pixel);
      park();

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
